// File: rtl/osc_freq_monitor_pkg.sv
// Shared monitor types: state encoding and default period/tolerance/timeout constants.
// The status-register block uses the same defaults, so it can decode PERIOD without a separate copy.
package osc_freq_monitor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_EXP_PERIOD = 50;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_TIMEOUT    = 200;
  localparam int GOOD_W         = 4;

endpackage

// File: rtl/osc_mon_sync_edge.sv
// osc_mon_sync_edge: 2-flop synchronizer on an asynchronous input, followed by a registered rising-edge pulse.
// Latency: the pulse is high in the 3rd i_clk cycle after i_async rises. There is no backpressure, and every edge is reported.
module osc_mon_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/osc_freq_monitor.sv
// osc_freq_monitor: measures each OSC_IN period in CLK cycles, then qualifies the oscillator (LOCKED/FAULT/STUCK).
// Latency: PERIOD/status update 4 CLK after an OSC_IN rise. There is no backpressure. Defining OSC_FREQ_MONITOR_IRQ_EN adds IRQ/IRQ_CLR.
module osc_freq_monitor
  import osc_freq_monitor_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             OSC_IN,
  input  logic             ENABLE,
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  input  logic             IRQ_CLR,
  output logic             IRQ,
`endif
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             FAULT,
  output logic             STUCK
);

  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0]     C_TIMEOUT = PW'(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_TO_N    = CNT_W'(TIMEOUT);
  localparam logic [PW-1:0]     C_EXP     = PW'(EXP_PERIOD);
  localparam logic [PW-1:0]     C_TOL     = PW'(TOL);
  localparam logic [GOOD_W-1:0] C_LOCK    = GOOD_W'(LOCK_CNT);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_period;
  logic                r_period_vld;
  logic [GOOD_W-1:0]   r_good;
  logic [GOOD_W-1:0]   w_good_nxt;
  logic                r_stuck;
  logic                w_stuck_nxt;
  logic                r_armed;
  logic                w_rise;
  logic [PW-1:0]       w_elapsed;
  logic [CNT_W-1:0]    w_period;
  logic [PW-1:0]       w_per_x;
  logic                w_in_win;
  logic                w_measure;
  logic                w_timeout;
  logic                w_running;

  osc_mon_sync_edge u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_async (OSC_IN),
    .o_rise  (w_rise)
  );

  // r_cnt counts the cycles since the last pulse minus one, so that w_elapsed is the period ending at this cycle.
  assign w_elapsed = {1'b0, r_cnt} + PW'(1);
  assign w_period  = (w_elapsed >= C_TIMEOUT) ? C_TO_N : w_elapsed[CNT_W-1:0];
  assign w_per_x   = {1'b0, w_period};
  assign w_in_win  = ((w_per_x + C_TOL) >= C_EXP) && (w_per_x <= (C_EXP + C_TOL));
  assign w_running = (r_state == ST_ACQ) || (r_state == ST_LOCKED);
  assign w_measure = w_rise && r_armed;
  assign w_timeout = !w_rise && w_running && (w_elapsed >= C_TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_stuck_nxt = r_stuck;
    if (!ENABLE) begin
      w_state_nxt = ST_IDLE;
      w_good_nxt  = '0;
      w_stuck_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_stuck_nxt = 1'b1;
          end else if (w_measure) begin
            if (w_in_win) begin
              w_good_nxt = r_good + GOOD_W'(1);
              if ((r_good + GOOD_W'(1)) == C_LOCK) w_state_nxt = ST_LOCKED;
            end else begin
              w_good_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_stuck_nxt = 1'b1;
          end else if (w_measure && !w_in_win) begin
            w_state_nxt = ST_FAULT;
            w_stuck_nxt = 1'b0;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_good       <= '0;
      r_stuck      <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_good       <= w_good_nxt;
      r_stuck      <= w_stuck_nxt;
      r_period_vld <= ENABLE && w_measure;
      if (ENABLE && w_measure) r_period <= w_period;
      if (!ENABLE || (r_state == ST_IDLE)) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
      end else if (w_rise) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (r_cnt != C_TO_N) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  // A new event wins over IRQ_CLR in the same cycle, so that no loss of lock is missed.
  assign w_irq_set = ((w_state_nxt == ST_FAULT) && (r_state != ST_FAULT)) ||
                     ((r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_irq <= 1'b0;
    else         r_irq <= w_irq_set | (r_irq & ~IRQ_CLR);
  end

  assign IRQ = r_irq;
`endif

  assign PERIOD       = r_period;
  assign PERIOD_VALID = r_period_vld;
  assign LOCKED       = (r_state == ST_LOCKED);
  assign FAULT        = (r_state == ST_FAULT);
  assign STUCK        = r_stuck;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Bench for osc_freq_monitor: directed scenarios plus randomized periods and enable drops, checked against a per-period model.
// Build with OSC_FREQ_MONITOR_IRQ_EN defined to also cover IRQ/IRQ_CLR.
module tb_osc_freq_monitor;

  localparam int EXP  = 50;
  localparam int TOL  = 2;
  localparam int LOCK = 4;
  localparam int TMO  = 200;

  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       osc;
  logic       en;
  logic [7:0] period;
  logic       period_vld;
  logic       locked;
  logic       fault;
  logic       stuck;
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic       irq_clr;
  logic       irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_good, m_period, prev_p;
  bit m_armed, m_valid, m_stuck, m_irq;

  always #10 clk = ~clk;

  osc_freq_monitor #(
    .CNT_W(8), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT(TMO)
  ) dut (
    .CLK          (clk),
    .RESETN       (rst_n),
    .OSC_IN       (osc),
    .ENABLE       (en),
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    .IRQ_CLR      (irq_clr),
    .IRQ          (irq),
`endif
    .PERIOD       (period),
    .PERIOD_VALID (period_vld),
    .LOCKED       (locked),
    .FAULT        (fault),
    .STUCK        (stuck)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void set_mode(input int nm);
    if ((nm == M_FAULT && m_mode != M_FAULT) || (m_mode == M_LOCK && nm != M_LOCK)) m_irq = 1'b1;
    m_mode = nm;
  endfunction

  function automatic void model_clear();
    m_mode = M_IDLE; m_good = 0; m_period = 0; prev_p = 0;
    m_armed = 1'b0; m_valid = 1'b0; m_stuck = 1'b0; m_irq = 1'b0;
  endfunction

  // One OSC_IN rise: e is the spacing in CLK cycles from the previous rise.
  function automatic void model_rise(input int e);
    int  per;
    bit  ok;
    m_valid = 1'b0;
    if (m_mode != M_IDLE) begin
      if (!m_armed) begin
        m_armed = 1'b1;
      end else begin
        per      = (e > TMO) ? TMO : e;
        m_period = per;
        m_valid  = 1'b1;
        ok       = (per >= EXP - TOL) && (per <= EXP + TOL);
        if (m_mode == M_ACQ) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK) set_mode(M_LOCK);
          end else begin
            m_good = 0;
          end
        end else if (m_mode == M_LOCK && !ok) begin
          m_stuck = 1'b0;
          set_mode(M_FAULT);
        end
      end
    end
  endfunction

  task automatic check_status(input string tag);
    check_val({tag, "/vld"},    32'(period_vld), 32'(m_valid));
    check_val({tag, "/period"}, 32'(period),     32'(m_period));
    check_val({tag, "/locked"}, 32'(locked),     32'(m_mode == M_LOCK));
    check_val({tag, "/fault"},  32'(fault),      32'(m_mode == M_FAULT));
    check_val({tag, "/stuck"},  32'(stuck),      32'(m_stuck));
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    check_val({tag, "/irq"},    32'(irq),        32'(m_irq));
`endif
  endtask

  // Called on a negedge: rises OSC_IN now and returns p cycles later, at the negedge of the next rise.
  task automatic drive_period(input int p);
    osc = 1'b1;
    for (int c = 1; c <= p; c++) begin
      @(negedge clk);
      if (c == p / 2) osc = 1'b0;
      if (c == 4) begin
        model_rise(prev_p);
        check_status("rise");
      end
      if (c == 5) check_val("vld_one_cycle", 32'(period_vld), 32'd0);
    end
    prev_p = p;
  endtask

  task automatic drop_enable();
    en = 1'b0;
    @(negedge clk);
    set_mode(M_IDLE);
    m_good = 0; m_armed = 1'b0; m_stuck = 1'b0; m_valid = 1'b0;
    check_status("disable");
    en = 1'b1;
    @(negedge clk);
    set_mode(M_ACQ);
  endtask

  // Holds OSC_IN low following a drive_period(last_p). The stuck fault must land exactly TMO cycles after that pulse.
  task automatic hold_low(input int last_p);
    for (int k = last_p - 4; k < TMO - 1; k++) @(negedge clk);
    m_valid = 1'b0;
    check_status("pre_timeout");
    @(negedge clk);
    m_stuck = 1'b1;
    set_mode(M_FAULT);
    check_status("timeout");
    prev_p = 1000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_status("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_mode(M_ACQ);
  endtask

`ifdef OSC_FREQ_MONITOR_IRQ_EN
  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    m_irq = 1'b0;
    check_val("irq_clr", 32'(irq), 32'd0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq4 [9];
    int bnd  [7];
    seq4 = '{50, 50, 50, 53, 50, 50, 50, 50, 50};
    bnd  = '{50, 48, 52, 47, 53, 200, 50};
    rst_n = 1'b0; osc = 1'b0; en = 1'b0;
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    irq_clr = 1'b0;
`endif
    model_clear();
    #25;
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_status("idle");
    en = 1'b1;
    @(negedge clk);
    set_mode(M_ACQ);

    // Nominal 1 MHz: one arming rise, then lock on the 4th valid period.
    for (int i = 0; i < 7; i++) drive_period(EXP);
    // Stretched period while locked.
    drive_period(54);
    for (int i = 0; i < 3; i++) drive_period(EXP);
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    clear_irq();
`endif
    // Disable out of FAULT, then reacquire.
    drop_enable();
    for (int i = 0; i < 6; i++) drive_period(EXP);
    drop_enable();
    // Good count restarts after a single bad period.
    foreach (seq4[i]) drive_period(seq4[i]);
    // Window edges, a period of exactly TMO (rise wins), then no edge at all.
    drop_enable();
    foreach (bnd[i]) drive_period(bnd[i]);
    hold_low(bnd[6]);
    drive_period(EXP);
    // Reset in mid-acquisition, then a full reacquire.
    drop_enable();
    for (int i = 0; i < 3; i++) drive_period(EXP);
    do_reset();
    for (int i = 0; i < 6; i++) drive_period(EXP);

    for (int i = 0; i < 60; i++) begin
      int r;
      int p;
      r = int'($urandom_range(99));
      if (r < 8) begin
        drop_enable();
      end else if (r < 12) begin
`ifdef OSC_FREQ_MONITOR_IRQ_EN
        clear_irq();
`else
        drive_period(EXP);
`endif
      end else begin
        if (r < 75)      p = EXP - TOL + int'($urandom_range(2 * TOL));
        else if (r < 88) p = EXP + TOL + 1 + int'($urandom_range(7));
        else             p = EXP - TOL - 1 - int'($urandom_range(7));
        drive_period(p);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
